// File: rtl/rf_pkg.sv
// Register-file write-port sharing: widths, types and write-source encoding
// shared by the writeback arbiter and its scoreboard.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    typedef enum logic {
        SRC_WB = 1'b0,
        SRC_LU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard for long-latency results.
// Ports: set (issue), clear (LU write landing), rs1/rs2 busy lookups, popcount.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic [ADDR_W:0]   pending_count
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Set is applied after clear: a new issue to a register whose
    // previous result lands on the same edge keeps it outstanding.
    always_comb begin
        pending_d = pending_q;
        if (clr_en)
            pending_d[clr_addr] = 1'b0;
        if (set_en)
            pending_d[set_addr] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            pending_q <= '0;
        else
            pending_q <= pending_d;
    end

    assign rs1_busy = pending_q[rs1_addr] & (rs1_addr != '0);
    assign rs2_busy = pending_q[rs2_addr] & (rs2_addr != '0);

    always_comb begin
        pending_count = '0;
        for (int i = 0; i < NUM_REGS; i++)
            pending_count = pending_count + {{ADDR_W{1'b0}}, pending_q[i]};
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between WB and the long-latency unit.
// Ports: wb_*/lu_* handshakes, issue_*, rs*_busy/stall, rf_write_*, grant_src.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int DATA_W   = REG_DATA_W,
    parameter int NUM_REGS = 2 ** ADDR_W,
    parameter int ARB_MODE = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_addr,
    input  logic [DATA_W-1:0] lu_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              stall,
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              grant_src,
    output logic [ADDR_W:0]   pending_count
);

    wb_src_e           last_grant;
    wb_src_e           grant_q;
    logic              wb_win;
    logic              lu_win;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // WB takes the port when alone, always in fixed mode, and in
    // round-robin mode when LU had the previous grant.
    always_comb begin
        wb_win = wb_valid &
                 (!lu_valid || (ARB_MODE == 0) || (last_grant == SRC_LU));
        lu_win = lu_valid & !wb_win;
    end

    assign wb_ready = wb_win;
    assign lu_ready = lu_win;
    assign sel_addr = lu_win ? lu_addr : wb_addr;
    assign sel_data = lu_win ? lu_data : wb_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
            grant_q         <= SRC_WB;
            last_grant      <= SRC_LU;
        end else if (wb_win || lu_win) begin
            // x0 writes still handshake but never reach the array
            rf_write_enable <= (sel_addr != '0);
            rf_write_addr   <= sel_addr;
            rf_write_data   <= sel_data;
            grant_q         <= lu_win ? SRC_LU : SRC_WB;
            last_grant      <= lu_win ? SRC_LU : SRC_WB;
        end else begin
            rf_write_enable <= 1'b0;
        end
    end

    assign grant_src = grant_q;

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clock         (clock),
        .reset_n       (reset_n),
        .set_en        (issue_valid),
        .set_addr      (issue_addr),
        .clr_en        (rf_write_enable & (grant_q == SRC_LU)),
        .clr_addr      (rf_write_addr),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .pending_count (pending_count)
    );

    assign stall = rs1_busy | rs2_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus corner sequences.
// Two instances: round-robin (main) and fixed priority (contention only).
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        wb_valid, lu_valid, issue_valid;
    logic [4:0]  wb_addr, lu_addr, issue_addr, rs1_addr, rs2_addr;
    logic [31:0] wb_data, lu_data;

    logic        wb_ready, lu_ready, rs1_busy, rs2_busy, stall;
    logic        rf_we, grant_src;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [5:0]  pend;

    logic        wb_ready0, lu_ready0, rs1_busy0, rs2_busy0, stall0;
    logic        rf_we0, grant_src0;
    logic [4:0]  rf_wa0;
    logic [31:0] rf_wd0;
    logic [5:0]  pend0;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    regfile_wb_arbiter #(.ARB_MODE(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready),
        .lu_addr(lu_addr), .lu_data(lu_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .stall(stall),
        .rf_write_enable(rf_we), .rf_write_addr(rf_wa),
        .rf_write_data(rf_wd), .grant_src(grant_src),
        .pending_count(pend)
    );

    regfile_wb_arbiter #(.ARB_MODE(0)) dut_fixed (
        .clock(clock), .reset_n(reset_n),
        .wb_valid(wb_valid), .wb_ready(wb_ready0),
        .wb_addr(wb_addr), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready0),
        .lu_addr(lu_addr), .lu_data(lu_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy0), .rs2_busy(rs2_busy0), .stall(stall0),
        .rf_write_enable(rf_we0), .rf_write_addr(rf_wa0),
        .rf_write_data(rf_wd0), .grant_src(grant_src0),
        .pending_count(pend0)
    );

    // register_file model fed by the round-robin instance
    logic [31:0] rf [32];
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    always @(posedge clock) if (rf_we) rf[rf_wa] <= rf_wd;

    typedef struct {
        logic        wv; logic [4:0] wa; logic [31:0] wd;
        logic        lv; logic [4:0] la; logic [31:0] ld;
        logic        iv; logic [4:0] ia;
        logic [4:0]  r1; logic [4:0] r2;
        logic        e_wr, e_lr, e_b1, e_b2, e_st;
        logic [5:0]  e_pc;
        logic        e_we; logic [4:0] e_wa; logic [31:0] e_wd;
        logic        e_gs;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        wb_valid = 0; wb_addr = 0; wb_data = 0;
        lu_valid = 0; lu_addr = 0; lu_data = 0;
        issue_valid = 0; issue_addr = 0;
        rs1_addr = 0; rs2_addr = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        idle();
        reset_n = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1;
    endtask

    function automatic vec_t mk(
        input logic wv, input logic [4:0] wa, input logic [31:0] wd,
        input logic lv, input logic [4:0] la, input logic [31:0] ld,
        input logic iv, input logic [4:0] ia,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic e_wr, input logic e_lr,
        input logic e_b1, input logic e_b2, input logic e_st,
        input logic [5:0] e_pc,
        input logic e_we, input logic [4:0] e_wa,
        input logic [31:0] e_wd, input logic e_gs);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd;
        v.lv = lv; v.la = la; v.ld = ld;
        v.iv = iv; v.ia = ia; v.r1 = r1; v.r2 = r2;
        v.e_wr = e_wr; v.e_lr = e_lr;
        v.e_b1 = e_b1; v.e_b2 = e_b2; v.e_st = e_st;
        v.e_pc = e_pc; v.e_we = e_we; v.e_wa = e_wa;
        v.e_wd = e_wd; v.e_gs = e_gs;
        return v;
    endfunction

    vec_t vt [16];
    logic [3:0] rr_pat;

    initial begin
        vt[0]  = mk(0,0,0, 0,0,0, 0,0, 0,0,   0,0,0,0,0,0, 0,0,0,0);
        vt[1]  = mk(1,5,32'h11111111, 0,0,0, 0,0, 0,0,
                    1,0,0,0,0,0, 1,5,32'h11111111,0);
        vt[2]  = mk(0,0,0, 0,0,0, 0,0, 0,0,   0,0,0,0,0,0, 0,0,0,0);
        vt[3]  = mk(0,0,0, 0,0,0, 1,10, 10,0, 0,0,0,0,0,0, 0,0,0,0);
        vt[4]  = mk(0,0,0, 0,0,0, 0,0, 10,0,  0,0,1,0,1,1, 0,0,0,0);
        vt[5]  = mk(0,0,0, 1,10,32'hCAFEBABE, 0,0, 10,0,
                    0,1,1,0,1,1, 1,10,32'hCAFEBABE,1);
        vt[6]  = mk(0,0,0, 0,0,0, 0,0, 10,0,  0,0,1,0,1,1, 0,0,0,0);
        vt[7]  = mk(0,0,0, 0,0,0, 0,0, 10,0,  0,0,0,0,0,0, 0,0,0,0);
        vt[8]  = mk(0,0,0, 0,0,0, 1,20, 0,20, 0,0,0,0,0,0, 0,0,0,0);
        vt[9]  = mk(1,20,32'h20202020, 0,0,0, 0,0, 0,20,
                    1,0,0,1,1,1, 1,20,32'h20202020,0);
        vt[10] = mk(0,0,0, 0,0,0, 0,0, 0,20,  0,0,0,1,1,1, 0,0,0,0);
        vt[11] = mk(0,0,0, 1,20,32'h0BADF00D, 0,0, 0,20,
                    0,1,0,1,1,1, 1,20,32'h0BADF00D,1);
        vt[12] = mk(0,0,0, 0,0,0, 0,0, 0,20,  0,0,0,1,1,1, 0,0,0,0);
        vt[13] = mk(0,0,0, 0,0,0, 0,0, 0,20,  0,0,0,0,0,0, 0,0,0,0);
        vt[14] = mk(0,0,0, 1,9,32'h99999999, 0,0, 9,0,
                    0,1,0,0,0,0, 1,9,32'h99999999,1);
        vt[15] = mk(0,0,0, 0,0,0, 0,0, 0,0,   0,0,0,0,0,0, 0,0,0,0);

        idle();
        reset_n = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset rf_we", rf_we, 0);
        chk("reset rf_wa", rf_wa, 0);
        chk("reset rf_wd", rf_wd, 0);
        chk("reset grant_src", grant_src, 0);
        chk("reset pending", pend, 0);
        @(negedge clock);
        reset_n = 1;

        foreach (vt[i]) begin
            @(negedge clock);
            wb_valid = vt[i].wv; wb_addr = vt[i].wa; wb_data = vt[i].wd;
            lu_valid = vt[i].lv; lu_addr = vt[i].la; lu_data = vt[i].ld;
            issue_valid = vt[i].iv; issue_addr = vt[i].ia;
            rs1_addr = vt[i].r1; rs2_addr = vt[i].r2;
            #1;
            chk($sformatf("v%0d wb_ready", i), wb_ready, vt[i].e_wr);
            chk($sformatf("v%0d lu_ready", i), lu_ready, vt[i].e_lr);
            chk($sformatf("v%0d rs1_busy", i), rs1_busy, vt[i].e_b1);
            chk($sformatf("v%0d rs2_busy", i), rs2_busy, vt[i].e_b2);
            chk($sformatf("v%0d stall", i), stall, vt[i].e_st);
            chk($sformatf("v%0d pending", i), pend, vt[i].e_pc);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d rf_we", i), rf_we, vt[i].e_we);
            if (vt[i].e_we) begin
                chk($sformatf("v%0d rf_wa", i), rf_wa, vt[i].e_wa);
                chk($sformatf("v%0d rf_wd", i), rf_wd, vt[i].e_wd);
                chk($sformatf("v%0d grant_src", i), grant_src, vt[i].e_gs);
            end
        end
        chk("rf x5", rf[5], 32'h11111111);
        chk("rf x10", rf[10], 32'hCAFEBABE);
        chk("rf x20", rf[20], 32'h0BADF00D);
        chk("rf x9", rf[9], 32'h99999999);

        // reset lands while an LU write to x7 is in flight
        @(negedge clock);
        idle();
        issue_valid = 1; issue_addr = 7; rs1_addr = 7;
        @(negedge clock);
        issue_valid = 0;
        lu_valid = 1; lu_addr = 7; lu_data = 32'h77777777;
        #1;
        chk("rst-mid lu_ready", lu_ready, 1);
        chk("rst-mid stall before", stall, 1);
        @(posedge clock);
        #1;
        chk("rst-mid rf_we in flight", rf_we, 1);
        #1;
        reset_n = 0;
        #1;
        chk("rst-mid rf_we", rf_we, 0);
        chk("rst-mid pending", pend, 0);
        chk("rst-mid stall", stall, 0);
        @(negedge clock);
        lu_valid = 0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1;
        @(posedge clock);
        #1;
        chk("rst-mid rf x7", rf[7], 0);

        // both requesters held for four cycles
        rr_pat = 4'b1010;
        @(negedge clock);
        idle();
        wb_valid = 1; wb_addr = 1; wb_data = 32'hA1;
        lu_valid = 1; lu_addr = 2; lu_data = 32'hB2;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr%0d wb_ready", k), wb_ready, !rr_pat[k]);
            chk($sformatf("rr%0d lu_ready", k), lu_ready, rr_pat[k]);
            chk($sformatf("fx%0d wb_ready", k), wb_ready0, 1);
            chk($sformatf("fx%0d lu_ready", k), lu_ready0, 0);
            @(posedge clock);
            #1;
            chk($sformatf("rr%0d grant_src", k), grant_src, rr_pat[k]);
            chk($sformatf("fx%0d grant_src", k), grant_src0, 0);
            @(negedge clock);
        end
        idle();

        // LU result for x12 lands on the edge of a new issue to x12
        @(negedge clock);
        issue_valid = 1; issue_addr = 12;
        @(negedge clock);
        issue_valid = 0;
        lu_valid = 1; lu_addr = 12; lu_data = 32'h12121212;
        rs1_addr = 12;
        #1;
        chk("same-edge lu_ready", lu_ready, 1);
        @(negedge clock);
        lu_valid = 0;
        issue_valid = 1; issue_addr = 12;
        @(negedge clock);
        issue_valid = 0;
        #1;
        chk("same-edge rs1_busy", rs1_busy, 1);
        chk("same-edge stall", stall, 1);
        chk("same-edge pending", pend, 1);
        chk("same-edge rf x12", rf[12], 32'h12121212);

        // x0 write and issue
        do_reset();
        wb_valid = 1; wb_addr = 0; wb_data = 32'hDEADBEEF;
        issue_valid = 1; issue_addr = 0; rs1_addr = 0;
        #1;
        chk("x0 wb_ready", wb_ready, 1);
        @(posedge clock);
        #1;
        chk("x0 rf_we", rf_we, 0);
        @(negedge clock);
        idle();
        #1;
        chk("x0 pending", pend, 0);
        chk("x0 rs1_busy", rs1_busy, 0);
        @(posedge clock);
        #1;
        chk("x0 rf x0", rf[0], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of register_file and shares it between two writers: the pipeline writeback stage (WB) and the long-latency unit (LU, i.e. mul/div or a load-miss return).
- Arbitrates with valid/ready handshakes and registers the winning write onto the register-file write port.
- Keeps a per-register scoreboard of outstanding LU writes and raises decode-stage stall on RAW hazards against them.

Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- NUM_REGS, 32, registers tracked (2**ADDR_W)
- ARB_MODE, 1, 0 = fixed priority (WB wins), 1 = round-robin

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- wb_valid  in  1  WB write request
- wb_ready  out  1  WB request accepted this cycle
- wb_addr  in  ADDR_W  WB destination register
- wb_data  in  DATA_W  WB write data
- lu_valid  in  1  LU write request
- lu_ready  out  1  LU request accepted this cycle
- lu_addr  in  ADDR_W  LU destination register
- lu_data  in  DATA_W  LU write data
- issue_valid  in  1  LU op issued; marks issue_addr pending
- issue_addr  in  ADDR_W  destination of issued LU op
- rs1_addr, rs2_addr  in  ADDR_W  decode-stage source registers
- rs1_busy, rs2_busy  out  1  source register has pending LU write
- stall  out  1  rs1_busy | rs2_busy
- rf_write_enable  out  1  to register_file write_enable
- rf_write_addr  out  ADDR_W  to register_file write_addr
- rf_write_data  out  DATA_W  to register_file write_data
- grant_src  out  1  source of current rf write (0 = WB, 1 = LU)
- pending_count  out  ADDR_W+1  popcount of scoreboard

Behaviour:
- Reset (reset_n low, async):
  - rf_write_enable=0, rf_write_addr=0, rf_write_data=0, grant_src=0.
  - Scoreboard cleared, pending_count=0, last_grant=LU (so WB wins the first contention).
  - Reset mid-operation drops any in-flight write and all pending bits.
- Arbitration (combinational):
  - ready is asserted only for the winner, and only when that requester's valid is high; never both ready in one cycle.
  - Only one valid: it wins.
  - Both valid, ARB_MODE=0: WB wins.
  - Both valid, ARB_MODE=1: the requester that did not win last wins.
  - last_grant updates on every accepted grant.
  - The loser holds valid/addr/data stable until accepted. Sustained throughput is one write per cycle.
- Write stage:
  - Request accepted at edge E: rf_write_* and grant_src are registered at E.
  - register_file captures the write at edge E+1.
  - No acceptance at E: rf_write_enable=0 at E; addr/data hold their previous values.
- x0:
  - Accepted request with addr=0 completes the handshake but drives rf_write_enable=0.
  - issue to x0 is ignored; rs*_busy for x0 is always 0.
- Scoreboard:
  - Bit[issue_addr] is set at the edge where issue_valid=1.
  - Bit[rf_write_addr] is cleared at edge E+1 when grant_src=1 and rf_write_enable=1, i.e. the same edge the data lands. On the following cycle stall drops and the combinational read returns the new value.
  - Set and clear of the same register at the same edge: set wins (a newer op is outstanding).
  - WB writes never touch the scoreboard.
  - rs*_busy and stall are combinational from the scoreboard. pending_count is combinational popcount.
- LU writes to a register whose bit is already clear are still performed. No error flag.

Decomposition:
- Shared package rf_pkg:
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32.
  - typedef reg_addr_t, reg_data_t.
  - enum wb_src_e {SRC_WB, SRC_LU}.
- One natural sub-module: rf_scoreboard (set/clear vector, busy lookups, popcount). Arbiter and write register stay in the top.

Test Plan:
1. Reset: reset_n=0 mid-stream with LU write in flight to x7 -> rf_write_enable=0 immediately, pending_count=0, stall=0. After release, x7 in register_file is unchanged.
2. Single write: wb_valid, addr=5, data=0x11111111 -> wb_ready=1 same cycle, rf_write_enable=1 next cycle, x5 reads 0x11111111 after the following edge.
3. Contention, ARB_MODE=1:
   - WB and LU both valid for 4 cycles -> grants alternate WB, LU, WB, LU.
   - Same stimulus with ARB_MODE=0 -> WB always wins and lu_ready stays 0.
4. Scoreboard RAW:
   - issue x10, rs1_addr=10 -> rs1_busy=1, stall=1, pending_count=1.
   - LU write x10=0xCAFEBABE accepted at E -> stall stays 1 through E+1, drops after E+1, x10 reads 0xCAFEBABE.
5. Same-edge set/clear: LU write to x12 lands on the same edge as a new issue to x12 -> bit stays set, stall=1, pending_count=1.
6. x0: WB write x0=0xDEADBEEF and issue x0 -> handshake completes, rf_write_enable=0, x0 reads 0, rs1_busy(x0)=0, pending_count=0.
